// File: rtl/drr_pifo_pkg.sv
// Shared DRR/PIFO definitions: entry layout {tag, overflow, round, addr} and dequeue FSM states.
package drr_pifo_pkg;

  localparam int PIFO_OVERFLOW_WIDTH = 1;
  localparam int PIFO_ROUND_WIDTH    = 18;
  localparam int PIFO_ADDR_WIDTH     = 12;
  localparam int PIFO_WIDTH          = 1 + PIFO_OVERFLOW_WIDTH + PIFO_ROUND_WIDTH + PIFO_ADDR_WIDTH;
  localparam int POP_TIMEOUT         = 15;

  localparam int ADDR_LSB  = 0;
  localparam int ROUND_LSB = ADDR_LSB + PIFO_ADDR_WIDTH;
  localparam int OVF_LSB   = ROUND_LSB + PIFO_ROUND_WIDTH;
  localparam int TAG_LSB   = OVF_LSB + PIFO_OVERFLOW_WIDTH;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_DECODE = 2'd2,
    ST_EMIT   = 2'd3
  } deq_state_e;

endpackage

// File: rtl/pifo_entry_decode.sv
// Splits a PIFO entry and classifies its rank against global virtual time.
module pifo_entry_decode
  import drr_pifo_pkg::*;
#(
  parameter int OVF_W   = PIFO_OVERFLOW_WIDTH,
  parameter int ROUND_W = PIFO_ROUND_WIDTH,
  parameter int ADDR_W  = PIFO_ADDR_WIDTH,
  parameter int ENT_W   = PIFO_WIDTH
) (
  input  logic [ENT_W-1:0]   entry,
  input  logic [OVF_W-1:0]   ovf_g,
  input  logic [ROUND_W-1:0] round_g,
  output logic               tag,
  output logic [OVF_W-1:0]   ovf,
  output logic [ROUND_W-1:0] round,
  output logic [ADDR_W-1:0]  addr,
  output logic               wrap,
  output logic               advance,
  output logic               stale
);

  localparam int RND_LO = ADDR_W;
  localparam int OVF_LO = RND_LO + ROUND_W;
  localparam int TAG_LO = OVF_LO + OVF_W;

  assign tag   = entry[TAG_LO];
  assign ovf   = entry[OVF_LO +: OVF_W];
  assign round = entry[RND_LO +: ROUND_W];
  assign addr  = entry[0 +: ADDR_W];

  // Epoch change is detected by equality only; rounds compare unsigned within an epoch.
  assign wrap    = tag && (ovf != ovf_g);
  assign advance = tag && (ovf == ovf_g) && (round >= round_g);
  assign stale   = tag && (ovf == ovf_g) && (round <  round_g);

endmodule

// File: rtl/drr_pifo_dequeue_tracker.sv
// Dequeue side of the DRR PIFO: pops one entry per egress request, returns its address
// and tracks the global virtual time fed back to the enqueue-side rank engine.
module drr_pifo_dequeue_tracker
  import drr_pifo_pkg::*;
#(
  parameter int PIFO_OVERFLOW_WIDTH = drr_pifo_pkg::PIFO_OVERFLOW_WIDTH,
  parameter int PIFO_ROUND_WIDTH    = drr_pifo_pkg::PIFO_ROUND_WIDTH,
  parameter int PIFO_ADDR_WIDTH     = drr_pifo_pkg::PIFO_ADDR_WIDTH,
  parameter int PIFO_WIDTH          = drr_pifo_pkg::PIFO_WIDTH,
  parameter int POP_TIMEOUT         = drr_pifo_pkg::POP_TIMEOUT
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic                           deq_req_valid,
  output logic                           deq_req_ready,
  output logic                           deq_resp_valid,
  output logic                           deq_resp_ok,
  output logic [PIFO_ADDR_WIDTH-1:0]     deq_resp_addr,
  input  logic                           pifo_empty,
  output logic                           pifo_pop,
  input  logic                           pifo_pop_valid,
  input  logic [PIFO_WIDTH-1:0]          pifo_pop_data,
  output logic                           last_pifo_valid,
  output logic [PIFO_OVERFLOW_WIDTH-1:0] last_pifo_overflow,
  output logic [PIFO_ROUND_WIDTH-1:0]    last_pifo_round,
  output logic [15:0]                    stale_cnt
);

  localparam int CNT_W = $clog2(POP_TIMEOUT + 1);

  deq_state_e                     state;
  logic [CNT_W-1:0]               wait_cnt;
  logic [PIFO_WIDTH-1:0]          ent_q;
  logic                           pend_ok;
  logic [PIFO_ADDR_WIDTH-1:0]     pend_addr;

  logic                           d_tag, d_wrap, d_adv, d_stale;
  logic [PIFO_OVERFLOW_WIDTH-1:0] d_ovf;
  logic [PIFO_ROUND_WIDTH-1:0]    d_round;
  logic [PIFO_ADDR_WIDTH-1:0]     d_addr;

  pifo_entry_decode #(
    .OVF_W   (PIFO_OVERFLOW_WIDTH),
    .ROUND_W (PIFO_ROUND_WIDTH),
    .ADDR_W  (PIFO_ADDR_WIDTH),
    .ENT_W   (PIFO_WIDTH)
  ) u_dec (
    .entry   (ent_q),
    .ovf_g   (last_pifo_overflow),
    .round_g (last_pifo_round),
    .tag     (d_tag),
    .ovf     (d_ovf),
    .round   (d_round),
    .addr    (d_addr),
    .wrap    (d_wrap),
    .advance (d_adv),
    .stale   (d_stale)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state              <= ST_IDLE;
      wait_cnt           <= '0;
      ent_q              <= '0;
      pend_ok            <= 1'b0;
      pend_addr          <= '0;
      deq_req_ready      <= 1'b1;
      deq_resp_valid     <= 1'b0;
      deq_resp_ok        <= 1'b0;
      deq_resp_addr      <= '0;
      pifo_pop           <= 1'b0;
      last_pifo_valid    <= 1'b0;
      last_pifo_overflow <= '0;
      last_pifo_round    <= '0;
      stale_cnt          <= '0;
    end else begin
      pifo_pop        <= 1'b0;
      deq_resp_valid  <= 1'b0;
      last_pifo_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (deq_req_valid) begin
            deq_req_ready <= 1'b0;
            if (pifo_empty) begin
              pend_ok   <= 1'b0;
              pend_addr <= '0;
              state     <= ST_EMIT;
            end else begin
              pifo_pop <= 1'b1;
              wait_cnt <= '0;
              state    <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          // A response on the timeout cycle still wins over the abort.
          if (pifo_pop_valid) begin
            ent_q <= pifo_pop_data;
            state <= ST_DECODE;
          end else if (wait_cnt == CNT_W'(POP_TIMEOUT)) begin
            pend_ok   <= 1'b0;
            pend_addr <= '0;
            state     <= ST_EMIT;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        ST_DECODE: begin
          pend_ok   <= d_tag;
          pend_addr <= d_tag ? d_addr : '0;
          if (d_wrap || d_adv) begin
            last_pifo_overflow <= d_ovf;
            last_pifo_round    <= d_round;
            last_pifo_valid    <= 1'b1;
          end
          if (d_stale && (stale_cnt != 16'hFFFF))
            stale_cnt <= stale_cnt + 16'd1;
          state <= ST_EMIT;
        end
        ST_EMIT: begin
          deq_resp_valid <= 1'b1;
          deq_resp_ok    <= pend_ok;
          deq_resp_addr  <= pend_addr;
          deq_req_ready  <= 1'b1;
          state          <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
